sc_io_inport: RTL and testbench

SC_IO_INPORT -- requirements
Module: sc_io_inport

---
 rtl/sc_io_inport.sv | 154 +++++++++++++++
 tb/tb_sc_io_inport.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_io_inport.sv
// sc_io_inport: memory-mapped input window with synchronized, debounced switches and a sticky key-press flag.
// Build macro SC_INPORT_DEBOUNCE_EN enables per-bit debounce counters; without it bits are synchronize-only.
`timescale 1ns/1ps

module sc_io_inport #(
    parameter int unsigned DB_CYCLES = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_00C0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  in_port0,
    input  logic [3:0]  in_port1,
    input  logic        in_port_sub,
    input  logic [31:0] addr,
    input  logic        rd,
    output logic [31:0] io_read_data,
    output logic        key_event
);

    localparam int NBITS   = 9;
    localparam int KEY_BIT = 8;

    typedef enum logic [1:0] {
        REG_PORT0 = 2'd0,
        REG_PORT1 = 2'd1,
        REG_KEY   = 2'd2,
        REG_COUNT = 2'd3
    } reg_sel_e;

    if (DB_CYCLES == 0 || DB_CYCLES > 65535) begin : g_bad_db_cycles
        $error("sc_io_inport: DB_CYCLES must be in 1..65535");
    end

    // Bit order: [3:0] in_port0, [7:4] in_port1, [8] key.
    logic [NBITS-1:0] raw_in;
    assign raw_in = {in_port_sub, in_port1, in_port0};

    logic [NBITS-1:0] sync1_q, sync1_d;
    logic [NBITS-1:0] sync2_q, sync2_d;
    logic [NBITS-1:0] db_cur, db_next;
    logic             sticky_q, sticky_d;
    logic [7:0]       press_cnt_q, press_cnt_d;

    always_comb begin
        sync1_d = raw_in;
        sync2_d = sync1_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

`ifdef SC_INPORT_DEBOUNCE_EN
    localparam logic [15:0] DB_LAST = 16'(DB_CYCLES - 1);

    logic [NBITS-1:0] db_q, db_d;
    logic [15:0]      db_cnt_q [NBITS];
    logic [15:0]      db_cnt_d [NBITS];

    // A counter only runs while the synchronized bit disagrees with the debounced bit.
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < NBITS; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 16'd1;
                end
            end
        end
    end

    // NOTE: the counter array is cleared element by element so reset discards any partial count.
    always_ff @(posedge clock) begin
        if (reset) begin
            db_q <= '0;
            for (int i = 0; i < NBITS; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            db_q <= db_d;
            for (int i = 0; i < NBITS; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    assign db_cur  = db_q;
    assign db_next = db_d;
`else
    assign db_cur  = sync2_q;
    assign db_next = sync2_d;
`endif

    logic     win_hit;
    reg_sel_e reg_sel;
    logic     clr_read;
    logic     press_evt;

    assign win_hit   = (addr[31:4] == BASE_ADDR[31:4]);
    assign reg_sel   = reg_sel_e'(addr[3:2]);
    assign clr_read  = rd && win_hit && (reg_sel == REG_KEY);
    // Rising edge of the debounced key, seen in the cycle before it is registered.
    assign press_evt = db_next[KEY_BIT] && !db_cur[KEY_BIT];

    always_comb begin
        sticky_d    = sticky_q;
        press_cnt_d = press_cnt_q + {7'd0, press_evt};
        if (press_evt) begin
            sticky_d = 1'b1;
        end else if (clr_read) begin
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sticky_q    <= 1'b0;
            press_cnt_q <= '0;
        end else begin
            sticky_q    <= sticky_d;
            press_cnt_q <= press_cnt_d;
        end
    end

    // NOTE: the read mux assigns a default first so no path leaves io_read_data unassigned (no latch).
    always_comb begin
        io_read_data = '0;
        if (win_hit) begin
            unique case (reg_sel)
                REG_PORT0: io_read_data = {28'd0, db_cur[3:0]};
                REG_PORT1: io_read_data = {28'd0, db_cur[7:4]};
                REG_KEY:   io_read_data = {30'd0, sticky_q, db_cur[KEY_BIT]};
                REG_COUNT: io_read_data = {24'd0, press_cnt_q};
                default:   io_read_data = '0;
            endcase
        end
    end

    assign key_event = sticky_q;

    logic unused_addr_lo;
    assign unused_addr_lo = ^addr[1:0];

endmodule

// File: tb/tb_sc_io_inport.sv
// Testbench for sc_io_inport: directed scenarios plus random stimulus, reads scored against a
// sliding-window reference model; works with or without SC_INPORT_DEBOUNCE_EN.
`timescale 1ns/1ps

module tb_sc_io_inport;

    localparam int          DB   = 16;
    localparam logic [31:0] BASE = 32'h0000_00C0;
`ifdef SC_INPORT_DEBOUNCE_EN
    localparam bit DBEN = 1'b1;
    localparam int LAT  = 2 + DB;
`else
    localparam bit DBEN = 1'b0;
    localparam int LAT  = 2;
`endif
    localparam logic [31:0] A_P0  = BASE;
    localparam logic [31:0] A_P1  = BASE + 32'h4;
    localparam logic [31:0] A_KEY = BASE + 32'h8;
    localparam logic [31:0] A_CNT = BASE + 32'hC;

    logic        clock;
    logic        reset;
    logic [3:0]  in_port0;
    logic [3:0]  in_port1;
    logic        in_port_sub;
    logic [31:0] addr;
    logic        rd;
    logic [31:0] io_read_data;
    logic        key_event;

    int total = 0;
    int bad   = 0;

    logic [31:0] sb_q[$];

    sc_io_inport #(.DB_CYCLES(DB), .BASE_ADDR(BASE)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_port0     (in_port0),
        .in_port1     (in_port1),
        .in_port_sub  (in_port_sub),
        .addr         (addr),
        .rd           (rd),
        .io_read_data (io_read_data),
        .key_event    (key_event)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: the synchronizer is a 2-sample delay; a debounced bit flips once the
    // last DB synchronized samples all disagree with it (plain history window, no counters).
    logic [8:0]  m_s1, m_s2, m_db;
    logic        m_flag;
    logic [7:0]  m_cnt;
    logic [8:0]  m_win[$];

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a[31:4] != BASE[31:4]) return 32'h0;
        case (a[3:2])
            2'd0:    return {28'd0, m_db[3:0]};
            2'd1:    return {28'd0, m_db[7:4]};
            2'd2:    return {30'd0, m_flag, m_db[8]};
            default: return {24'd0, m_cnt};
        endcase
    endfunction

    always @(posedge clock) begin : model
        logic [8:0] raw_now;
        logic [8:0] new_db;
        bit         all_diff;
        raw_now = {in_port_sub, in_port1, in_port0};
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_db = '0; m_flag = 1'b0; m_cnt = '0;
            m_win.delete();
        end else begin
            if (DBEN) begin
                m_win.push_back(m_s2);
                if (m_win.size() > DB) void'(m_win.pop_front());
                new_db = m_db;
                if (m_win.size() == DB) begin
                    for (int b = 0; b < 9; b++) begin
                        all_diff = 1'b1;
                        foreach (m_win[j]) if (m_win[j][b] == m_db[b]) all_diff = 1'b0;
                        if (all_diff) new_db[b] = ~m_db[b];
                    end
                end
            end else begin
                new_db = m_s1;
            end
            if (new_db[8] && !m_db[8]) begin
                m_flag = 1'b1;
                m_cnt  = m_cnt + 8'd1;
            end else if (rd && addr[31:4] == BASE[31:4] && addr[3:2] == 2'd2) begin
                m_flag = 1'b0;
            end
            m_s2 = m_s1;
            m_s1 = raw_now;
            m_db = new_db;
        end
    end

    // Monitor: key_event every cycle, and each read strobe against the scoreboard.
    always @(negedge clock) begin
        check("key_event", {31'd0, key_event}, {31'd0, m_flag});
        if (rd) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_underflow at %0t: got read %h expected no read", $time, io_read_data);
            end else begin
                check("sb_read", io_read_data, sb_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_read(input logic [31:0] a);
        rd   = 1'b1;
        addr = a;
        sb_q.push_back(model_read(a));
        tick();
        rd = 1'b0;
    endtask

    task automatic do_read_chk(input logic [31:0] a, input string name, input logic [31:0] exp);
        rd   = 1'b1;
        addr = a;
        sb_q.push_back(model_read(a));
        #1;
        check(name, io_read_data, exp);
        tick();
        rd = 1'b0;
    endtask

    task automatic press();
        in_port_sub = 1'b1;
        repeat (LAT + 2) tick();
        in_port_sub = 1'b0;
        repeat (LAT + 2) tick();
    endtask

    task automatic latency_p0(input logic [3:0] oldv, input logic [3:0] newv);
        in_port0 = newv;
        addr     = A_P0;
        for (int k = 1; k <= LAT + 2; k++) begin
            tick();
            check("p0_latency", io_read_data, (k >= LAT) ? {28'd0, newv} : {28'd0, oldv});
        end
    endtask

    initial begin : stim
        int h0, h1, hs;
        reset = 1'b1; rd = 1'b0; addr = '0;
        in_port0 = 4'hA; in_port1 = 4'h3; in_port_sub = 1'b1;
        repeat (3) tick();
        in_port0 = 4'h0; in_port1 = 4'h0; in_port_sub = 1'b0;
        tick();
        reset = 1'b0;

        // Post-reset register contents.
        do_read_chk(A_P0,  "rst_p0",  32'h0);
        do_read_chk(A_P1,  "rst_p1",  32'h0);
        do_read_chk(A_KEY, "rst_key", 32'h0);
        do_read_chk(A_CNT, "rst_cnt", 32'h0);

        // Debounce latency on in_port0.
        latency_p0(4'h0, 4'h9);
        latency_p0(4'h9, 4'h5);

        // in_port1 chatter for 10 cycles, then settles at 0.
        addr = A_P1;
        for (int i = 0; i < 10 + LAT + 3; i++) begin
            in_port1 = (i < 10 && (i % 2 == 0)) ? 4'hF : 4'h0;
            tick();
            check("p1_chatter", io_read_data, DBEN ? 32'h0 : model_read(A_P1));
        end

        // Single-cycle glitch: propagates only when debounce is disabled.
        in_port1 = 4'h6;
        tick();
        in_port1 = 4'h0;
        check("p1_glitch_e1", io_read_data, 32'h0);
        tick();
        check("p1_glitch_e2", io_read_data, DBEN ? 32'h0 : 32'h6);
        tick();
        check("p1_glitch_e3", io_read_data, 32'h0);
        repeat (LAT + 2) tick();

        // Three clean presses, then a clearing read of the key register.
        repeat (3) press();
        check("press3_flag", {31'd0, key_event}, 32'h1);
        do_read_chk(A_CNT, "press3_cnt", 32'h3);
        do_read_chk(A_KEY, "press3_key", 32'h2);
        check("press3_cleared", {31'd0, key_event}, 32'h0);

        // Clearing read in the very cycle the debounced key rises: set wins.
        in_port_sub = 1'b1;
        repeat (LAT - 1) tick();
        do_read_chk(A_KEY, "race_read", 32'h0);
        check("race_flag", {31'd0, key_event}, 32'h1);
        do_read_chk(A_CNT, "race_cnt", 32'h4);
        do_read_chk(A_KEY, "race_key", 32'h3);
        in_port_sub = 1'b0;
        repeat (LAT + 2) tick();

        // Press counter wrap 255 -> 0; unmapped read has no effect.
        repeat (251) press();
        do_read_chk(A_CNT, "wrap_255", 32'hFF);
        do_read_chk(A_KEY, "wrap_clr", 32'h2);
        press();
        do_read_chk(A_CNT, "wrap_0", 32'h0);
        check("wrap_flag", {31'd0, key_event}, 32'h1);
        do_read_chk(BASE + 32'h10, "unmapped", 32'h0);
        check("unmapped_flag", {31'd0, key_event}, 32'h1);
        do_read_chk(A_CNT, "unmapped_cnt", 32'h0);
        do_read_chk(A_KEY, "final_key", 32'h2);

        // Reset in the middle of a debounce, key held through it: exactly one event afterwards.
        in_port_sub = 1'b1;
        repeat (LAT - 1) tick();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        for (int k = 1; k <= LAT + 2; k++) begin
            tick();
            check("held_evt", {31'd0, key_event}, (k >= LAT) ? 32'h1 : 32'h0);
        end
        repeat (20) tick();
        do_read_chk(A_CNT, "held_cnt", 32'h1);
        do_read_chk(A_KEY, "held_key", 32'h3);
        in_port_sub = 1'b0;
        repeat (LAT + 2) tick();

        // Random phase, scored entirely by the model.
        h0 = 0; h1 = 0; hs = 0;
        for (int c = 0; c < 4000; c++) begin
            if (h0 == 0) begin in_port0 = 4'($urandom); h0 = $urandom_range(1, DB + 6); end
            if (h1 == 0) begin in_port1 = 4'($urandom); h1 = $urandom_range(1, DB + 6); end
            if (hs == 0) begin in_port_sub = 1'($urandom); hs = $urandom_range(1, DB + 8); end
            h0--; h1--; hs--;
            reset = (c == 2000);
            case ($urandom_range(0, 3))
                0:       addr = BASE + 32'($urandom_range(0, 15));
                1:       addr = A_KEY + 32'($urandom_range(0, 3));
                2:       addr = BASE + 32'h10 + 32'($urandom_range(0, 15));
                default: addr = $urandom;
            endcase
            rd = ($urandom_range(0, 2) == 0);
            if (rd) sb_q.push_back(model_read(addr));
            tick();
        end
        rd    = 1'b0;
        reset = 1'b0;
        tick();

        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL sb_leftover: got %0d pending reads expected 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
